// File: rtl/vram_fill_arbiter.sv
// vram_fill_arbiter: owns the single VRAM write port. CPU byte writes always
// win; a row-range fill engine writes one character code into every cell of
// rows [first,last] using only the cycles the CPU leaves idle. All outputs are
// registered, so a write chosen in cycle N is on the port during cycle N+1.
module vram_fill_arbiter #(
  parameter int WRITE_ADDR_SIZE = 16,
  parameter int COLS            = 80,
  parameter int ROWS            = 30,
  parameter int X_BITS          = 7,
  parameter int Y_BITS          = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_wr_valid,
  input  logic [WRITE_ADDR_SIZE-2:0] cpu_wr_addr,
  input  logic [7:0]                 cpu_wr_data,
  input  logic                       fill_start,
  input  logic [7:0]                 fill_char,
  input  logic [Y_BITS-1:0]          fill_row_first,
  input  logic [Y_BITS-1:0]          fill_row_last,
  input  logic                       fill_abort,
  output logic                       fill_busy,
  output logic                       fill_done,
  output logic                       fill_err,
  output logic [WRITE_ADDR_SIZE-1:0] vram_write_address,
  output logic [7:0]                 vram_write_data
);

  // Zero bits between the write-enable MSB and the {y,x} cell field.
  localparam int PAD_BITS = WRITE_ADDR_SIZE - 1 - Y_BITS - X_BITS;

  // MSB high means "no write this cycle".
  localparam logic [WRITE_ADDR_SIZE-1:0] NO_WRITE = {1'b1, {(WRITE_ADDR_SIZE-1){1'b0}}};

  localparam logic [X_BITS-1:0] X_LAST  = X_BITS'(COLS - 1);
  localparam logic [Y_BITS:0]   ROWS_CT = (Y_BITS + 1)'(ROWS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [X_BITS-1:0]          x_q, x_d;
  logic [Y_BITS-1:0]          y_q, y_d;
  logic [Y_BITS-1:0]          last_q, last_d;
  logic [7:0]                 char_q, char_d;
  logic                       err_sel_q, err_sel_d;
  logic [WRITE_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [7:0]                 data_q, data_d;
  logic                       busy_q, done_q, err_q;

  // Cell address of (y,x) with the write enable asserted (MSB low).
  function automatic logic [WRITE_ADDR_SIZE-1:0] cell_addr(input logic [Y_BITS-1:0] y,
                                                           input logic [X_BITS-1:0] x);
    cell_addr = {1'b0, {PAD_BITS{1'b0}}, y, x};
  endfunction

  // A range is rejected if it is reversed or runs past the bottom row.
  function automatic logic range_bad(input logic [Y_BITS-1:0] first,
                                     input logic [Y_BITS-1:0] last);
    range_bad = (first > last) || ({1'b0, last} >= ROWS_CT);
  endfunction

  // Next-state, fill counters and write-port mux.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    last_d    = last_q;
    char_d    = char_q;
    err_sel_d = err_sel_q;
    addr_d    = NO_WRITE;
    data_d    = data_q;

    // The CPU owns the port whenever it asks; the fill simply waits.
    if (cpu_wr_valid) begin
      addr_d = {1'b0, cpu_wr_addr};
      data_d = cpu_wr_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Abort is meaningless here, so start alone decides.
        if (fill_start) begin
          if (range_bad(fill_row_first, fill_row_last)) begin
            err_sel_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            err_sel_d = 1'b0;
            last_d    = fill_row_last;
            char_d    = fill_char;
            x_d       = '0;
            y_d       = fill_row_first;
            state_d   = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (fill_abort) begin
          // Abort beats any pending fill write, including the final one.
          err_sel_d = 1'b0;
          state_d   = ST_DONE;
        end else if (!cpu_wr_valid) begin
          addr_d = cell_addr(y_q, x_q);
          data_d = char_q;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + Y_BITS'(1);
            if (y_q == last_q) begin
              state_d = ST_DONE;
            end
          end else begin
            x_d = x_q + X_BITS'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, counters and registered outputs; reset abandons any fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      err_sel_q <= 1'b0;
      addr_q    <= NO_WRITE;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      err_sel_q <= err_sel_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= (state_d == ST_FILL);
      done_q    <= (state_q == ST_DONE);
      err_q     <= (state_q == ST_DONE) && err_sel_q;
    end
  end

  // Fill parameters latched on an accepted start; no reset needed.
  always_ff @(posedge clk) begin
    last_q <= last_d;
    char_q <= char_d;
  end

  assign fill_busy          = busy_q;
  assign fill_done          = done_q;
  assign fill_err           = err_q;
  assign vram_write_address = addr_q;
  assign vram_write_data    = data_q;

endmodule
